mem_access_unit: RTL
====================

Name: mem_access_unit

Overview:
- MEM-stage load/store engine. Sits directly downstream of the EX-stage ALU and uses the registered ALU_result as the effective address.
- Performs byte/half/word loads and stores against a data memory port that inserts wait states, using a req/ack handshake.
- Stalls the pipeline while a transaction is outstanding. Raises MIPS address-error exceptions (AdEL/AdES) on misaligned accesses.

Parameters:
- TIMEOUT_CYCLES, 16: maximum ack wait before a bus error is raised (used only with MEM_TIMEOUT_EN).

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- valid_in  in  1  MEM-stage instruction valid this cycle
- mem_op  in  4  memory operation code (MEMOP_* from shared package)
- addr  in  32  effective address (registered ALU_result)
- alu_ov  in  1  EX overflow flag for this instruction
- store_data  in  32  rt value for stores
- flush  in  1  discard the current instruction's result (exception/branch kill)
- dmem_req  out  1  memory request
- dmem_we  out  1  1 = write
- dmem_addr  out  32  word-aligned address ({addr[31:2],2'b00})
- dmem_be  out  4  byte enables
- dmem_wdata  out  32  lane-replicated write data
- dmem_ack  in  1  memory completion (one-cycle pulse)
- dmem_rdata  in  32  read data, valid with dmem_ack
- stall  out  1  hold upstream stages
- done  out  1  one-cycle pulse: instruction finished
- load_data  out  32  extended load result, valid with done
- adel  out  1  load address error, pulses with done
- ades  out  1  store address error, pulses with done
- bad_vaddr  out  32  faulting address, valid with adel/ades
- bus_err  out  1  timeout error, pulses with done

Behaviour:
- Reset: every output is 0 and the FSM is in IDLE. An asserted reset mid-transaction drops dmem_req asynchronously; there is no done for the aborted op.
- FSM states: IDLE, REQ, RESP.
- IDLE, with valid_in=1 and mem_op!=MEMOP_NONE:
  - Latch op, addr and store_data.
  - If alu_ov=1: accept the instruction, do not access memory, pulse done with no error (overflow already handled upstream).
  - Else if misaligned (LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]!=0): no request is issued. Next cycle pulse done together with adel (loads) or ades (stores); bad_vaddr = addr.
  - Otherwise go to REQ.
- IDLE, with valid_in=1 and mem_op=MEMOP_NONE: pulse done the next cycle.
- REQ:
  - dmem_req=1. dmem_addr, dmem_we, dmem_be and dmem_wdata are held stable until ack.
  - stall=1.
  - On dmem_ack go to RESP.
- RESP:
  - Loads: load_data = selected lane, sign- or zero-extended.
  - done=1, stall=0, then return to IDLE.
- Latency:
  - Minimum: acceptance -> done = 2 cycles (ack in the first REQ cycle).
  - Error or no-op path: done 1 cycle after acceptance.
- Lane select (little-endian):
  - Byte: lane = addr[1:0].
  - Half: addr[1] selects bits [15:0] or [31:16].
  - Store wdata: byte replicated x4, half replicated x2.
  - dmem_be: one-hot (SB), 0011/1100 (SH), 1111 (SW).
- valid_in while busy (REQ) is ignored; upstream must obey stall.
- flush:
  - Seen in REQ: the transaction still completes (the bus cannot be aborted), but done, load_data and all error flags are suppressed.
  - Seen in IDLE together with valid_in: the instruction is dropped.
- A dmem_ack in IDLE or RESP is ignored.

Optional Feature:
- MEM_TIMEOUT_EN defined:
  - A cycle counter runs in REQ.
  - If TIMEOUT_CYCLES elapse with no ack: drop dmem_req, pulse done with bus_err=1 and bad_vaddr=addr, return to IDLE.
  - A late ack arriving afterwards is ignored.
- Not defined: REQ waits indefinitely; bus_err is tied to 0.

Decomposition:
- Shared package/define file:
  - MEMOP_* encodings: NONE=0, LB, LBU, LH, LHU, LW, SB, SH, SW.
  - FSM state encodings.
  - ENABLE/DISABLE.
- One sub-module, mem_lane_align (combinational): computes byte enables, wdata replication, and load extraction/extension.

Test Plan:
- LW, addr=0x00001004, ack on 3rd REQ cycle, rdata=0xDEADBEEF -> dmem_addr=0x00001004, be=1111; stall high 3 cycles; done with load_data=0xDEADBEEF.
- LB, addr=0x00001003, rdata=0x80FF0011 -> be=1000; load_data=0xFFFFFF80. Same access as LBU -> 0x00000080.
- SH, addr=0x00002002, store_data=0x1234ABCD -> dmem_we=1, be=1100, wdata=0xABCDABCD.
- LW at 0x00001002 -> no dmem_req; next cycle done=1, adel=1, bad_vaddr=0x00001002. SH at 0x00002001 -> ades=1.
- Flush asserted during REQ of an LW -> bus completes, no done/load_data. Reset asserted mid-REQ -> dmem_req=0 immediately and all outputs 0.
- MEM_TIMEOUT_EN with TIMEOUT_CYCLES=16 and no ack -> done with bus_err=1 after 16 REQ cycles. Without the macro, stall stays high.

Source files
------------

// File: rtl/mem_access_unit_pkg.sv
// mem_access_unit_pkg: shared memory-op encodings, FSM states and op-class helpers.
package mem_access_unit_pkg;
  typedef enum logic [3:0] {
    MEMOP_NONE = 4'd0, MEMOP_LB, MEMOP_LBU, MEMOP_LH, MEMOP_LHU,
    MEMOP_LW, MEMOP_SB, MEMOP_SH, MEMOP_SW
  } memop_e;
  typedef enum logic [1:0] {IDLE, REQ, RESP} state_e;
  localparam logic ENABLE  = 1'b1;
  localparam logic DISABLE = 1'b0;
  function automatic logic is_store(memop_e op);
    return op inside {MEMOP_SB, MEMOP_SH, MEMOP_SW};
  endfunction
  function automatic logic is_byte(memop_e op);
    return op inside {MEMOP_LB, MEMOP_LBU, MEMOP_SB};
  endfunction
  function automatic logic is_half(memop_e op);
    return op inside {MEMOP_LH, MEMOP_LHU, MEMOP_SH};
  endfunction
  function automatic logic is_word(memop_e op);
    return op inside {MEMOP_LW, MEMOP_SW};
  endfunction
  function automatic logic misaligned(memop_e op, logic [1:0] a);
    return (is_half(op) && a[0]) || (is_word(op) && a != 2'b00);
  endfunction
endpackage

// File: rtl/mem_access_unit_lane_align.sv
// mem_lane_align: little-endian byte enables, store lane replication and load extraction/extension.
module mem_lane_align
  import mem_access_unit_pkg::*;
(
  input  memop_e      op,
  input  logic [1:0]  lane,
  input  logic [31:0] store_data,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] load_data
);
  logic [7:0] b;
  logic [15:0] h;
  logic sx;
  always_comb begin
    b = 8'(rdata >> {lane, 3'b000});
    h = lane[1] ? rdata[31:16] : rdata[15:0];
    sx = op inside {MEMOP_LB, MEMOP_LH};
    be = is_byte(op) ? 4'b0001 << lane : is_half(op) ? (lane[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    wdata = is_byte(op) ? {4{store_data[7:0]}} : is_half(op) ? {2{store_data[15:0]}} : store_data;
    load_data = is_byte(op) ? {{24{sx & b[7]}}, b} : is_half(op) ? {{16{sx & h[15]}}, h} : rdata;
  end
endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage load/store engine with req/ack bus, stall and AdEL/AdES.
// Define MEM_TIMEOUT_EN to raise bus_err after TIMEOUT_CYCLES without ack.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid_in,
  input  logic [3:0]  mem_op,
  input  logic [31:0] addr,
  input  logic        alu_ov,
  input  logic [31:0] store_data,
  input  logic        flush,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        stall,
  output logic        done,
  output logic [31:0] load_data,
  output logic        adel,
  output logic        ades,
  output logic [31:0] bad_vaddr,
  output logic        bus_err
);
  state_e state_q, state_d;
  memop_e op_q, op_in;
  logic [31:0] addr_q, sd_q, rdata_q, ld, wd;
  logic [3:0] be;
  logic acc_q, adel_q, ades_q, kill_q, berr_q;
  logic in_req, accept, mis, go_mem, timeout;
  assign op_in  = memop_e'(mem_op);
  assign in_req = state_q == REQ;
  assign accept = !in_req && valid_in && !flush;
  assign mis    = misaligned(op_in, addr[1:0]);
  assign go_mem = op_in != MEMOP_NONE && !alu_ov && !mis;
`ifdef MEM_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
  logic [CW-1:0] cnt_q;
  always_ff @(posedge clk or negedge reset)
    if (!reset) cnt_q <= '0;
    else cnt_q <= in_req ? cnt_q + 1'b1 : '0;
  assign timeout = in_req && !dmem_ack && cnt_q == CW'(TIMEOUT_CYCLES - 1);
`else
  assign timeout = 1'b0;
`endif
  always_ff @(posedge clk or negedge reset)
    if (!reset) state_q <= IDLE;
    else state_q <= state_d;
  always_comb begin
    state_d = in_req ? ((dmem_ack || timeout) ? RESP : REQ) : accept ? (go_mem ? REQ : RESP) : IDLE;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_q    <= MEMOP_NONE;
      addr_q  <= '0;
      sd_q    <= '0;
      rdata_q <= '0;
      acc_q   <= DISABLE;
      adel_q  <= DISABLE;
      ades_q  <= DISABLE;
      kill_q  <= DISABLE;
      berr_q  <= DISABLE;
    end else if (accept) begin
      op_q   <= op_in;
      addr_q <= addr;
      sd_q   <= store_data;
      acc_q  <= go_mem;
      adel_q <= !alu_ov && mis && !is_store(op_in);
      ades_q <= !alu_ov && mis && is_store(op_in);
      kill_q <= DISABLE;
      berr_q <= DISABLE;
    end else if (in_req) begin
      if (flush) kill_q <= ENABLE;
      if (dmem_ack) rdata_q <= dmem_rdata;
      if (timeout) begin
        berr_q <= ENABLE;
        acc_q  <= DISABLE;
      end
    end
  end
  mem_lane_align u_align (
    .op(op_q), .lane(addr_q[1:0]), .store_data(sd_q), .rdata(rdata_q),
    .be(be), .wdata(wd), .load_data(ld)
  );
  // Bus outputs are only driven in REQ so an idle or reset unit shows all zeros.
  assign dmem_req   = in_req;
  assign dmem_we    = in_req && is_store(op_q);
  assign dmem_addr  = in_req ? {addr_q[31:2], 2'b00} : '0;
  assign dmem_be    = in_req ? be : '0;
  assign dmem_wdata = dmem_we ? wd : '0;
  assign stall      = in_req;
  assign done       = state_q == RESP && !kill_q;
  assign load_data  = done && acc_q && !is_store(op_q) ? ld : '0;
  assign adel       = done && adel_q;
  assign ades       = done && ades_q;
  assign bus_err    = done && berr_q;
  assign bad_vaddr  = (adel || ades || bus_err) ? addr_q : '0;
endmodule
